// File: rtl/bram_stage_scheduler_pkg.sv
// Shared types for the BRAM stage scheduler: buffer lifecycle and stage handshake states.
package bram_stage_scheduler_pkg;

  localparam int unsigned NUM_BUF_DEFAULT = 3;

  typedef enum logic [2:0] {
    BUF_FREE      = 3'd0,
    BUF_WRITING   = 3'd1,
    BUF_FILLED    = 3'd2,
    BUF_FILTERING = 3'd3,
    BUF_FILTERED  = 3'd4,
    BUF_READING   = 3'd5
  } buf_state_t;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_ACK = 2'd1,
    S_BUSY     = 2'd2
  } stage_state_t;

endpackage

// File: rtl/bram_stage_scheduler_stage_sequencer.sv
// Start/idle handshake for one pipeline stage plus its ring pointer over the frame buffers.
module stage_sequencer
  import bram_stage_scheduler_pkg::*;
#(
  parameter int unsigned NUM_BUF = NUM_BUF_DEFAULT,
  parameter int unsigned IDX_W   = $clog2(NUM_BUF)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             ready_c,
  input  logic             idle,
  output logic             start,
  output logic [IDX_W-1:0] index,
  output logic [IDX_W-1:0] ptr,
  output logic             launch_c,
  output logic             done_c
);

  localparam logic [IDX_W-1:0] LAST_PTR = IDX_W'(NUM_BUF - 1);

  stage_state_t     state;
  stage_state_t     state_n;
  logic             start_n;
  logic [IDX_W-1:0] index_n;
  logic [IDX_W-1:0] ptr_n;

  // State, start pulse, granted index and pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      start <= 1'b0;
      index <= '0;
      ptr   <= '0;
    end else begin
      state <= state_n;
      start <= start_n;
      index <= index_n;
      ptr   <= ptr_n;
    end
  end

  // Next-state logic: launch on a ready buffer, wait for ack, wait for completion.
  always_comb begin
    state_n  = state;
    start_n  = 1'b0;
    index_n  = index;
    ptr_n    = ptr;
    launch_c = 1'b0;
    done_c   = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable && ready_c) begin
          launch_c = 1'b1;
          start_n  = 1'b1;
          index_n  = ptr;
          state_n  = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (!idle) begin
          state_n = S_BUSY;
        end
      end
      S_BUSY: begin
        if (idle) begin
          done_c  = 1'b1;
          ptr_n   = (ptr == LAST_PTR) ? '0 : ptr + IDX_W'(1);
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: rtl/bram_stage_scheduler.sv
// Rotates NUM_BUF frame BRAMs through writer -> filter -> reader, one buffer per stage at a time.
module bram_stage_scheduler
  import bram_stage_scheduler_pkg::*;
#(
  parameter int unsigned NUM_BUF = NUM_BUF_DEFAULT,
  parameter int unsigned IDX_W   = $clog2(NUM_BUF)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic             writer_start,
  output logic [IDX_W-1:0] writer_index,
  input  logic             writer_idle,
  output logic             filt_start,
  output logic [IDX_W-1:0] filt_index,
  input  logic             filt_idle,
  output logic             reader_start,
  output logic [IDX_W-1:0] reader_index,
  input  logic             reader_idle,
  output logic [3:0]       image_index_counter,
  output logic [2:0]       frames_in_flight
);

  buf_state_t       buf_q [NUM_BUF];
  buf_state_t       buf_d [NUM_BUF];
  logic [2:0]       fif_d;
  logic [IDX_W-1:0] wr_ptr;
  logic [IDX_W-1:0] filt_ptr;
  logic [IDX_W-1:0] rd_ptr;
  logic             wr_ready_c, filt_ready_c, rd_ready_c;
  logic             wr_launch_c, filt_launch_c, rd_launch_c;
  logic             wr_done_c, filt_done_c, rd_done_c;

  stage_sequencer #(.NUM_BUF(NUM_BUF), .IDX_W(IDX_W)) u_writer (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .ready_c  (wr_ready_c),
    .idle     (writer_idle),
    .start    (writer_start),
    .index    (writer_index),
    .ptr      (wr_ptr),
    .launch_c (wr_launch_c),
    .done_c   (wr_done_c)
  );

  stage_sequencer #(.NUM_BUF(NUM_BUF), .IDX_W(IDX_W)) u_filt (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .ready_c  (filt_ready_c),
    .idle     (filt_idle),
    .start    (filt_start),
    .index    (filt_index),
    .ptr      (filt_ptr),
    .launch_c (filt_launch_c),
    .done_c   (filt_done_c)
  );

  stage_sequencer #(.NUM_BUF(NUM_BUF), .IDX_W(IDX_W)) u_reader (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .ready_c  (rd_ready_c),
    .idle     (reader_idle),
    .start    (reader_start),
    .index    (reader_index),
    .ptr      (rd_ptr),
    .launch_c (rd_launch_c),
    .done_c   (rd_done_c)
  );

  // A stage may launch only when the buffer under its pointer holds its input state (registered).
  always_comb begin
    wr_ready_c   = 1'b0;
    filt_ready_c = 1'b0;
    rd_ready_c   = 1'b0;
    for (int unsigned i = 0; i < NUM_BUF; i++) begin
      if (wr_ptr   == IDX_W'(i) && buf_q[i] == BUF_FREE)     wr_ready_c   = 1'b1;
      if (filt_ptr == IDX_W'(i) && buf_q[i] == BUF_FILLED)   filt_ready_c = 1'b1;
      if (rd_ptr   == IDX_W'(i) && buf_q[i] == BUF_FILTERED) rd_ready_c   = 1'b1;
    end
  end

  // Buffer lifecycle updates; stages always address distinct buffers, so updates never collide.
  always_comb begin
    fif_d = '0;
    for (int unsigned i = 0; i < NUM_BUF; i++) begin
      buf_d[i] = buf_q[i];
      if (wr_ptr == IDX_W'(i)) begin
        if (wr_launch_c) buf_d[i] = BUF_WRITING;
        if (wr_done_c)   buf_d[i] = BUF_FILLED;
      end
      if (filt_ptr == IDX_W'(i)) begin
        if (filt_launch_c) buf_d[i] = BUF_FILTERING;
        if (filt_done_c)   buf_d[i] = BUF_FILTERED;
      end
      if (rd_ptr == IDX_W'(i)) begin
        if (rd_launch_c) buf_d[i] = BUF_READING;
        if (rd_done_c)   buf_d[i] = BUF_FREE;
      end
      if (buf_d[i] != BUF_FREE) fif_d = fif_d + 3'd1;
    end
  end

  // Buffer state array, occupancy count and completed-frame counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_BUF; i++) buf_q[i] <= BUF_FREE;
      frames_in_flight    <= '0;
      image_index_counter <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_BUF; i++) buf_q[i] <= buf_d[i];
      frames_in_flight <= fif_d;
      if (rd_done_c) image_index_counter <= image_index_counter + 4'd1;
    end
  end

endmodule

// File: tb/tb_bram_stage_scheduler.sv
// Randomized bench for bram_stage_scheduler against a frame-count reference model.
module tb_bram_stage_scheduler;

  localparam int NB = 3;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [2:0]    idle_drv = 3'b111;
  logic          writer_start, filt_start, reader_start;
  logic [IW-1:0] writer_index, filt_index, reader_index;
  logic [3:0]    image_index_counter;
  logic [2:0]    frames_in_flight;

  always #5 clk = ~clk;

  bram_stage_scheduler dut (
    .clk                 (clk),
    .reset               (reset),
    .enable              (enable),
    .writer_start        (writer_start),
    .writer_index        (writer_index),
    .writer_idle         (idle_drv[0]),
    .filt_start          (filt_start),
    .filt_index          (filt_index),
    .filt_idle           (idle_drv[1]),
    .reader_start        (reader_start),
    .reader_index        (reader_index),
    .reader_idle         (idle_drv[2]),
    .image_index_counter (image_index_counter),
    .frames_in_flight    (frames_in_flight)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: frames started/finished per stage and handshake phase (0 idle, 1 await ack, 2 busy).
  int started [3];
  int done    [3];
  int phase   [3];
  int exp_idx [3];

  // Stub stage behaviour.
  int st_ph  [3];
  int st_cnt [3];
  int ack_d  [3];
  int busy_d [3];
  bit rand_mode = 1'b0;
  bit stall = 1'b0;

  string nm [3] = '{"writer", "filt", "reader"};

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Input material available for stage s: a free buffer, a written frame, or a filtered frame.
  function automatic bit avail(input int s);
    if (s == 0) return (started[0] - done[2]) < NB;
    if (s == 1) return started[1] < done[0];
    return started[2] < done[1];
  endfunction

  task automatic step();
    bit [2:0] st;
    int       ix [3];
    bit       l  [3];
    @(negedge clk);
    st    = {reader_start, filt_start, writer_start};
    ix[0] = int'(writer_index);
    ix[1] = int'(filt_index);
    ix[2] = int'(reader_index);
    for (int s = 0; s < 3; s++) l[s] = 1'b0;
    if (reset) begin
      for (int s = 0; s < 3; s++) begin
        started[s] = 0; done[s] = 0; phase[s] = 0; exp_idx[s] = 0;
      end
    end else begin
      for (int s = 0; s < 3; s++) l[s] = enable && (phase[s] == 0) && avail(s);
      for (int s = 0; s < 3; s++) begin
        if (phase[s] == 1 && !idle_drv[s]) phase[s] = 2;
        else if (phase[s] == 2 && idle_drv[s]) begin
          phase[s] = 0;
          done[s]++;
        end
      end
      for (int s = 0; s < 3; s++) begin
        if (l[s]) begin
          exp_idx[s] = started[s] % NB;
          started[s]++;
          phase[s] = 1;
        end
      end
    end
    for (int s = 0; s < 3; s++) begin
      check_val({nm[s], "_start"}, int'(st[s]), int'(l[s]));
      check_val({nm[s], "_index"}, ix[s], exp_idx[s]);
    end
    check_val("frames_in_flight", int'(frames_in_flight), started[0] - done[2]);
    check_val("image_index_counter", int'(image_index_counter), done[2] % 16);
    // Stub responses for the next edge.
    for (int s = 0; s < 3; s++) begin
      if (reset) begin
        st_ph[s] = 0;
        idle_drv[s] = 1'b1;
      end else begin
        if (st[s]) begin
          st_ph[s] = 1;
          if (rand_mode) st_cnt[s] = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 3));
          else           st_cnt[s] = ack_d[s];
        end
        if (st_ph[s] == 1) begin
          if (st_cnt[s] == 0) begin
            idle_drv[s] = 1'b0;
            st_ph[s] = 2;
            st_cnt[s] = rand_mode ? int'($urandom_range(0, 6)) : busy_d[s];
          end else st_cnt[s]--;
        end else if (st_ph[s] == 2) begin
          if (st_cnt[s] > 0) st_cnt[s]--;
          else if (!(s == 2 && stall)) begin
            idle_drv[s] = 1'b1;
            st_ph[s] = 0;
          end
        end
      end
    end
  endtask

  initial begin
    for (int s = 0; s < 3; s++) begin
      started[s] = 0; done[s] = 0; phase[s] = 0; exp_idx[s] = 0;
      st_ph[s] = 0; st_cnt[s] = 0; ack_d[s] = 2; busy_d[s] = 10;
    end
    repeat (3) step();

    // First frame through all stages with fixed ack/busy timing.
    reset = 1'b0;
    enable = 1'b1;
    for (int k = 0; k < 400 && done[2] < 1; k++) step();
    check_val("count_after_first", int'(image_index_counter), 1);

    // Continuous frames up to five completed.
    for (int k = 0; k < 1500 && done[2] < 5; k++) step();
    check_val("count_after_five", int'(image_index_counter), 5);

    // Reader stalled: pipeline fills all buffers and writer must hold off.
    stall = 1'b1;
    repeat (150) step();
    check_val("stall_in_flight", int'(frames_in_flight), 3);
    check_val("stall_writer_start", int'(writer_start), 0);
    stall = 1'b0;
    repeat (60) step();

    // Randomized timing, late acks and enable toggling.
    rand_mode = 1'b1;
    for (int k = 0; k < 1500; k++) begin
      step();
      if ($urandom_range(0, 15) == 0) enable = ~enable;
    end
    enable = 1'b0;
    repeat (40) step();
    check_val("disabled_writer_start", int'(writer_start), 0);
    check_val("disabled_stages_idle", phase[0] + phase[1] + phase[2], 0);
    enable = 1'b1;

    // Reset while every stage is active.
    for (int k = 0; k < 3000 && !(phase[0] != 0 && phase[1] != 0 && phase[2] != 0); k++) step();
    check_val("all_busy_reached", int'(phase[0] != 0 && phase[1] != 0 && phase[2] != 0), 1);
    reset = 1'b1;
    step();
    check_val("reset_in_flight", int'(frames_in_flight), 0);
    check_val("reset_counter", int'(image_index_counter), 0);
    reset = 1'b0;

    // Sixteen frames after reset wrap the counter back to zero.
    for (int k = 0; k < 4000 && done[2] < 16; k++) step();
    if (done[2] < 16) check_val("wrap_timeout_frames", done[2], 16);
    check_val("counter_wrap", int'(image_index_counter), 0);
    repeat (5) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
